// File: rtl/set_mode_controller.sv
// rtl/set_mode_controller.sv - set-mode FSM with button debounce, idle timeout and field blink
module set_mode_controller #(
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int BLINK_CYC    = 12_500_000,
    parameter int TIMEOUT_S    = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1s,
    input  logic       sw_mode,
    input  logic       butt_increase,
    input  logic       butt_decrease,
    input  logic       butt_change,
    output logic       edit_active,
    output logic [2:0] field_sel,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       clk_hold,
    output logic [7:0] blink_mask
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BW = $clog2(BLINK_CYC + 1);
    localparam int IW = $clog2(TIMEOUT_S + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_S - 1);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_SET_A = 2'd1;
    localparam logic [1:0] ST_SET_B = 2'd2;
    localparam logic [1:0] ST_SET_C = 2'd3;

    // bit 0 = increase, bit 1 = decrease, bit 2 = change; all active-low
    logic [2:0]    raw, sync1, sync2, level, press;
    logic [DW-1:0] deb_cnt [3];

    assign raw = {butt_change, butt_decrease, butt_increase};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
            level <= '1;
            press <= '0;
            for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i] <= '0;
                    level[i]   <= sync2[i];
                    press[i]   <= ~sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic          inc_ev, dec_ev, chg_ev, any_ev;
    logic [1:0]    state, state_d;
    logic          entry_mode, entry_mode_d;
    logic [IW-1:0] idle_cnt, idle_d;
    logic [2:0]    field_d;
    logic          in_set, mode_abort, timeout, adj_ok, inc_d, dec_d, blink_restart;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    assign inc_ev = press[0];
    assign dec_ev = press[1];
    assign chg_ev = press[2];
    assign any_ev = |press;

    assign in_set        = (state != ST_RUN);
    assign mode_abort    = in_set && (sw_mode != entry_mode);
    assign timeout       = in_set && tick_1s && !any_ev && (idle_cnt == IDLE_LAST);
    assign adj_ok        = in_set && !mode_abort && !chg_ev;
    assign inc_d         = adj_ok && inc_ev && !dec_ev;
    assign dec_d         = adj_ok && dec_ev && !inc_ev;
    assign blink_restart = (state_d != state) || inc_d || dec_d;

    always_comb begin
        state_d      = state;
        entry_mode_d = entry_mode;
        if (mode_abort || timeout) begin
            state_d = ST_RUN;
        end else if (chg_ev) begin
            case (state)
                ST_RUN: begin
                    state_d      = ST_SET_A;
                    entry_mode_d = sw_mode;
                end
                ST_SET_A: state_d = ST_SET_B;
                ST_SET_B: state_d = ST_SET_C;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        idle_d = idle_cnt;
        if ((state_d != state) || !in_set || any_ev)
            idle_d = '0;
        else if (tick_1s && (idle_cnt != IW'(TIMEOUT_S)))
            idle_d = idle_cnt + 1'b1;
    end

    always_comb begin
        field_d = 3'd0;
        case (state_d)
            ST_SET_A: field_d = entry_mode_d ? 3'd4 : 3'd1;
            ST_SET_B: field_d = entry_mode_d ? 3'd5 : 3'd2;
            ST_SET_C: field_d = entry_mode_d ? 3'd6 : 3'd3;
            default:  field_d = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            entry_mode  <= 1'b0;
            idle_cnt    <= '0;
            edit_active <= 1'b0;
            field_sel   <= 3'd0;
            inc_pulse   <= 1'b0;
            dec_pulse   <= 1'b0;
            clk_hold    <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            state       <= state_d;
            entry_mode  <= entry_mode_d;
            idle_cnt    <= idle_d;
            edit_active <= (state_d != ST_RUN);
            field_sel   <= field_d;
            inc_pulse   <= inc_d;
            dec_pulse   <= dec_d;
            // calendar edits leave time running
            clk_hold    <= (state_d != ST_RUN) && !entry_mode_d;
            if (blink_restart || (state_d == ST_RUN)) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        blink_mask = 8'h00;
        if (blink_phase) begin
            case (field_sel)
                3'd1, 3'd4: blink_mask = 8'hC0;
                3'd2, 3'd5: blink_mask = 8'h30;
                3'd3:       blink_mask = 8'h0C;
                3'd6:       blink_mask = 8'h0F;
                default:    blink_mask = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_set_mode_controller.sv
// tb/tb_set_mode_controller.sv - randomized self-checking bench for set_mode_controller
module tb_set_mode_controller;

    localparam int D = 4;
    localparam int B = 8;
    localparam int T = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1s = 1'b0;
    logic       sw_mode = 1'b0;
    logic       butt_increase = 1'b1;
    logic       butt_decrease = 1'b1;
    logic       butt_change = 1'b1;
    logic       edit_active;
    logic [2:0] field_sel;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       clk_hold;
    logic [7:0] blink_mask;

    set_mode_controller #(.DEBOUNCE_CYC(D), .BLINK_CYC(B), .TIMEOUT_S(T)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .sw_mode(sw_mode),
        .butt_increase(butt_increase), .butt_decrease(butt_decrease), .butt_change(butt_change),
        .edit_active(edit_active), .field_sel(field_sel), .inc_pulse(inc_pulse),
        .dec_pulse(dec_pulse), .clk_hold(clk_hold), .blink_mask(blink_mask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int inc_cnt = 0, dec_cnt = 0, hold_cnt = 0;
    int total = 0, bad = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (inc_pulse === 1'b1) inc_cnt++;
        if (dec_pulse === 1'b1) dec_cnt++;
        if (clk_hold === 1'b1) hold_cnt++;
    end

    // reference model: edit step 0 = run, 1..3 = field within the group chosen at entry
    int   m_state = 0;
    logic m_mode = 1'b0;
    int   m_idle = 0;
    int   m_restart = 0;

    function automatic int exp_field();
        return (m_state == 0) ? 0 : m_state + (m_mode ? 3 : 0);
    endfunction

    function automatic logic [7:0] exp_mask(input int c);
        int f;
        f = exp_field();
        if (m_state == 0 || (((c - m_restart) / B) % 2) == 0) return 8'h00;
        case (f)
            1, 4:    return 8'hC0;
            2, 5:    return 8'h30;
            3:       return 8'h0C;
            default: return 8'h0F;
        endcase
    endfunction

    task automatic drive(input logic [2:0] pressed);
        butt_increase = ~pressed[0];
        butt_decrease = ~pressed[1];
        butt_change   = ~pressed[2];
    endtask

    // btns: bit0 inc, bit1 dec, bit2 change; glen 0 picks random bounce lengths
    task automatic press(input logic [2:0] btns, input int nglitch, input int glen);
        int t0, i0, d0, f_old, n;
        logic e_inc, e_dec;
        logic [7:0] em;
        i0 = inc_cnt;
        d0 = dec_cnt;
        f_old = exp_field();
        for (int g = 0; g < nglitch; g++) begin
            drive(btns);
            n = (glen > 0) ? glen : $urandom_range(1, D - 1);
            repeat (n) @(negedge clk);
            drive(3'b000);
            n = $urandom_range(1, 2);
            repeat (n) @(negedge clk);
        end
        drive(btns);
        t0 = cyc;
        e_inc = 1'b0;
        e_dec = 1'b0;
        if (btns[2]) begin
            if (m_state == 0) m_mode = sw_mode;
            m_state = (m_state + 1) % 4;
            m_restart = t0 + D + 3;
        end else if (m_state != 0) begin
            e_inc = btns[0] && !btns[1];
            e_dec = btns[1] && !btns[0];
            if (e_inc || e_dec) m_restart = t0 + D + 3;
        end
        m_idle = 0;
        repeat (D + 2) @(negedge clk);
        total++;
        if (field_sel !== 3'(f_old)) begin
            bad++; $display("FAIL press_early_field btn=%b field_sel=%0d want=%0d", btns, field_sel, f_old);
        end
        @(negedge clk);
        total++;
        if (field_sel !== 3'(exp_field())) begin
            bad++; $display("FAIL press_field btn=%b field_sel=%0d want=%0d", btns, field_sel, exp_field());
        end
        total++;
        if (edit_active !== (m_state != 0)) begin
            bad++; $display("FAIL press_edit_active btn=%b got=%b want=%b", btns, edit_active, m_state != 0);
        end
        total++;
        if (clk_hold !== (m_state != 0 && !m_mode)) begin
            bad++; $display("FAIL press_clk_hold btn=%b got=%b want=%b", btns, clk_hold, m_state != 0 && !m_mode);
        end
        total++;
        if ({inc_pulse, dec_pulse} !== {e_inc, e_dec}) begin
            bad++; $display("FAIL press_pulse_timing btn=%b got=%b%b want=%b%b", btns, inc_pulse, dec_pulse, e_inc, e_dec);
        end
        repeat (3) @(negedge clk);
        drive(3'b000);
        repeat (D + 4) @(negedge clk);
        total++;
        if (inc_cnt - i0 != int'(e_inc) || dec_cnt - d0 != int'(e_dec)) begin
            bad++; $display("FAIL press_pulse_count btn=%b inc=%0d dec=%0d want=%0d/%0d", btns, inc_cnt - i0, dec_cnt - d0, e_inc, e_dec);
        end
        em = exp_mask(cyc);
        total++;
        if (blink_mask !== em) begin
            bad++; $display("FAIL press_blink btn=%b got=%h want=%h", btns, blink_mask, em);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({edit_active, field_sel, inc_pulse, dec_pulse, clk_hold, blink_mask} !== 15'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", {edit_active, field_sel, inc_pulse, dec_pulse, clk_hold, blink_mask});
        end
        rst_n = 1'b1;
        m_state = 0; m_idle = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clock_fields();
        sw_mode = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) press(3'b100, 0, 0);
    endtask

    task automatic test_bounce_inc();
        press(3'b100, 0, 0);
        press(3'b001, 1, 2);
        press(3'b010, 2, 0);
        for (int i = 0; i < 3; i++) press(3'b100, 0, 0);
    endtask

    task automatic test_collide();
        press(3'b100, 0, 0);
        press(3'b100, 0, 0);
        press(3'b011, 0, 0);
        press(3'b101, 0, 0);
        press(3'b100, 0, 0);
    endtask

    task automatic test_calendar_abort();
        int h0;
        h0 = hold_cnt;
        sw_mode = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) press(3'b100, 0, 0);
        sw_mode = 1'b0;
        @(negedge clk);
        m_state = 0; m_idle = 0;
        total++;
        if (field_sel !== 3'd0 || edit_active !== 1'b0) begin
            bad++; $display("FAIL abort_to_run field_sel=%0d edit=%b want=0/0", field_sel, edit_active);
        end
        total++;
        if (hold_cnt != h0) begin
            bad++; $display("FAIL calendar_clk_hold cycles=%0d want=0", hold_cnt - h0);
        end
    endtask

    task automatic test_blink_timeout();
        logic [7:0] em;
        press(3'b100, 0, 0);
        for (int i = 0; i < 4 * B; i++) begin
            @(negedge clk);
            em = exp_mask(cyc);
            total++;
            if (blink_mask !== em) begin
                bad++; $display("FAIL blink_cycle n=%0d got=%h want=%h", i, blink_mask, em);
            end
        end
        for (int k = 0; k < T; k++) begin
            tick_1s = 1'b1;
            @(negedge clk);
            tick_1s = 1'b0;
            m_idle++;
            if (m_idle >= T) begin m_state = 0; m_idle = 0; end
            total++;
            if (field_sel !== 3'(exp_field()) || blink_mask !== exp_mask(cyc)) begin
                bad++; $display("FAIL timeout_tick k=%0d field=%0d mask=%h want=%0d/%h", k, field_sel, blink_mask, exp_field(), exp_mask(cyc));
            end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_edit();
        int i0;
        press(3'b100, 0, 0);
        press(3'b100, 0, 0);
        i0 = inc_cnt;
        drive(3'b001);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({edit_active, field_sel, inc_pulse, dec_pulse, clk_hold, blink_mask} !== 15'd0) begin
            bad++; $display("FAIL reset_mid_edit got=%h want=0", {edit_active, field_sel, inc_pulse, dec_pulse, clk_hold, blink_mask});
        end
        @(negedge clk);
        drive(3'b000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_state = 0; m_idle = 0;
        repeat (20) @(negedge clk);
        total++;
        if (inc_cnt != i0 || field_sel !== 3'd0) begin
            bad++; $display("FAIL reset_no_pulse inc=%0d field=%0d want=0/0", inc_cnt - i0, field_sel);
        end
    endtask

    task automatic test_random();
        int act;
        logic [7:0] em;
        for (int it = 0; it < 40; it++) begin
            act = $urandom_range(0, 9);
            if (act <= 2) press(3'b100, $urandom_range(0, 2), 0);
            else if (act <= 4) press(3'b001, $urandom_range(0, 2), 0);
            else if (act == 5) press(3'b010, $urandom_range(0, 2), 0);
            else if (act == 6) press(3'b011, $urandom_range(0, 2), 0);
            else if (act == 7) press($urandom_range(0, 1) ? 3'b101 : 3'b110, 0, 0);
            else begin
                if (act == 8) begin
                    tick_1s = 1'b1;
                    @(negedge clk);
                    tick_1s = 1'b0;
                    if (m_state != 0) begin
                        m_idle++;
                        if (m_idle >= T) begin m_state = 0; m_idle = 0; end
                    end
                end else begin
                    sw_mode = ~sw_mode;
                    @(negedge clk);
                    if (m_state != 0 && sw_mode != m_mode) begin m_state = 0; m_idle = 0; end
                end
                em = exp_mask(cyc);
                total++;
                if (field_sel !== 3'(exp_field()) || blink_mask !== em) begin
                    bad++; $display("FAIL random_step act=%0d field=%0d mask=%h want=%0d/%h", act, field_sel, blink_mask, exp_field(), em);
                end
                repeat (2) @(negedge clk);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clock_fields();
        test_bounce_inc();
        test_collide();
        test_calendar_abort();
        test_blink_timeout();
        test_reset_mid_edit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
